// File: rtl/pmc_pkg.sv
// Shared PMC definitions: sequencer geometry, state encodings, control-word layout.
package pmc_pkg;

  localparam int unsigned PMC_SEQ_WORD_W = 32;
  localparam int unsigned PMC_SEQ_LANES  = 16;
  localparam int unsigned PMC_SEQ_DIV_W  = 8;

  // Sequencer control word: half_div [7:0], bit_cnt [13:8], store_en [16]
  localparam logic [7:0]  PMC_REG_SEQ_CTRL       = 8'h40;
  localparam int unsigned PMC_SEQ_CTRL_HDIV_LSB  = 0;
  localparam int unsigned PMC_SEQ_CTRL_BCNT_LSB  = 8;
  localparam int unsigned PMC_SEQ_CTRL_STORE_BIT = 16;

  localparam logic [2:0] PMC_SEQ_IDLE  = 3'd0;
  localparam logic [2:0] PMC_SEQ_LOW   = 3'd1;
  localparam logic [2:0] PMC_SEQ_HIGH  = 3'd2;
  localparam logic [2:0] PMC_SEQ_STORE = 3'd3;
  localparam logic [2:0] PMC_SEQ_FIN   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = PMC_SEQ_IDLE,
    S_LOW   = PMC_SEQ_LOW,
    S_HIGH  = PMC_SEQ_HIGH,
    S_STORE = PMC_SEQ_STORE,
    S_FIN   = PMC_SEQ_FIN
  } pmc_seq_state_t;

  // Lane 0 occupies the least-significant word.
  typedef logic [PMC_SEQ_LANES-1:0][PMC_SEQ_WORD_W-1:0] pmc_data_t;

endpackage

// File: rtl/pmc_half_period_timer.sv
// Loadable down-counter timing one clk_sh phase; expire flags the phase's final cycle.
module pmc_half_period_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/pmc_shift_sequencer.sv
// Bit-serial shift engine: drives LANES column chains MSB first with a generated clk_sh
// while capturing the returning serial data into readback words.
module pmc_shift_sequencer
  import pmc_pkg::*;
#(
  parameter int unsigned LANES  = PMC_SEQ_LANES,
  parameter int unsigned WORD_W = PMC_SEQ_WORD_W,
  parameter int unsigned DIV_W  = PMC_SEQ_DIV_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [5:0]              bit_cnt,
  input  logic [DIV_W-1:0]        half_div,
  input  logic                    store_en,
  input  logic [LANES*WORD_W-1:0] dout,
  output logic [LANES*WORD_W-1:0] din,
  output logic [LANES-1:0]        sdo,
  input  logic [LANES-1:0]        sdi,
  output logic                    clk_sh,
  output logic                    store,
  output logic                    busy,
  output logic                    done
);

  typedef logic [LANES-1:0][WORD_W-1:0] lane_words_t;
  localparam logic [5:0] N_MAX = 6'(WORD_W);

  pmc_seq_state_t   state_q, state_d;
  lane_words_t      sr_q, sr_d, din_q, din_d;
  logic [LANES-1:0] cap_q, cap_d;
  logic [5:0]       cnt_q, cnt_d, n_q, n_d;
  logic [DIV_W-1:0] h_q, h_d;
  logic             st_en_q, st_en_d;
  logic             clk_sh_q, store_q, busy_q, done_q;
  logic             tmr_load, tmr_en, tmr_expire;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    h_d     = h_q;
    st_en_d = st_en_q;
    din_d   = din_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          sr_d    = dout;
          n_d     = (bit_cnt > N_MAX) ? N_MAX : bit_cnt;
          h_d     = (half_div == '0) ? DIV_W'(1) : half_div;
          st_en_d = store_en;
          cnt_d   = '0;
          state_d = (n_d == '0) ? S_FIN : S_LOW;
        end
      end
      S_LOW: begin
        if (tmr_expire) begin
          cap_d   = sdi;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (tmr_expire) begin
          for (int unsigned l = 0; l < LANES; l++) begin
            sr_d[l] = {sr_q[l][WORD_W-2:0], cap_q[l]};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_d == n_q) begin
            state_d = st_en_q ? S_STORE : S_FIN;
          end else begin
            state_d = S_LOW;
          end
        end
      end
      S_STORE: begin
        if (tmr_expire) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every transition, including a pending FIN, so din is never touched.
    if (abort) state_d = S_IDLE;
    if ((state_d == S_FIN) && (state_q != S_FIN)) din_d = sr_d;
  end

  // Every state change restarts the phase timer from H-1.
  assign tmr_load = (state_d != state_q);
  assign tmr_en   = (state_q == S_LOW) || (state_q == S_HIGH) || (state_q == S_STORE);

  pmc_half_period_timer #(
    .W (DIV_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (h_d - DIV_W'(1)),
    .en_i       (tmr_en),
    .expire_o   (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      cap_q    <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      h_q      <= '0;
      st_en_q  <= 1'b0;
      din_q    <= '0;
      clk_sh_q <= 1'b0;
      store_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      h_q      <= h_d;
      st_en_q  <= st_en_d;
      din_q    <= din_d;
      clk_sh_q <= (state_d == S_HIGH);
      store_q  <= (state_d == S_STORE);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_FIN);
    end
  end

  always_comb begin
    sdo = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      sdo[l] = sr_q[l][WORD_W-1];
    end
  end

  assign din    = din_q;
  assign clk_sh = clk_sh_q;
  assign store  = store_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_pmc_shift_sequencer.sv
// Directed bench for pmc_shift_sequencer: scoreboard of expected readback/done cycle per run.
module tb_pmc_shift_sequencer;
  import pmc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, store_en = 1'b0;
  logic [5:0]  bit_cnt = '0;
  logic [7:0]  half_div = '0;
  pmc_data_t   dout = '0;
  pmc_data_t   din;
  logic [15:0] sdo, sdi;
  logic [15:0] sdi_fix = '0;
  logic        loop_en = 1'b0;
  logic        clk_sh, store, busy, done;

  assign sdi = loop_en ? sdo : sdi_fix;

  pmc_shift_sequencer #(
    .LANES  (16),
    .WORD_W (32),
    .DIV_W  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .bit_cnt  (bit_cnt),
    .half_div (half_div),
    .store_en (store_en),
    .dout     (dout),
    .din      (din),
    .sdo      (sdo),
    .sdi      (sdi),
    .clk_sh   (clk_sh),
    .store    (store),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    pmc_data_t   din;
    int unsigned at;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0;
  int unsigned cyc = 0;
  int unsigned pulses = 0, busy_cyc = 0, store_cyc = 0, store_hi_clk = 0;
  int unsigned last_rise = 0, last_gap = 0;
  logic        clk_sh_prev = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: activity counters plus scoreboard pop on every done pulse.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (clk_sh && !clk_sh_prev) begin
      pulses++;
      last_gap  = cyc - last_rise;
      last_rise = cyc;
    end
    clk_sh_prev = clk_sh;
    if (busy) busy_cyc++;
    if (store) begin
      store_cyc++;
      if (clk_sh) store_hi_clk++;
    end
    if (done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d want none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("din", din, e.din);
        check("done_cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    check({name, "_completes"}, ok, 1);
  endtask

  task automatic run(input string name, input pmc_data_t d, input logic [5:0] bc,
                     input logic [7:0] hd, input logic se, input logic lp,
                     input logic [15:0] sfix, input pmc_data_t exp_din,
                     input int unsigned lat, input int unsigned exp_pulses,
                     input int unsigned exp_busy, input int unsigned exp_store);
    int unsigned p0, b0, s0;
    exp_t e;
    @(posedge clk); #1;
    dout = d; bit_cnt = bc; half_div = hd; store_en = se; loop_en = lp; sdi_fix = sfix;
    start = 1'b1;
    p0 = pulses; b0 = busy_cyc; s0 = store_cyc;
    e.din = exp_din;
    e.at  = cyc + lat;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    half_div = 8'd1;  // must be ignored while running
    wait_idle(name);
    check({name, "_pulses"}, pulses - p0, exp_pulses);
    check({name, "_busy_cycles"}, busy_cyc - b0, exp_busy);
    check({name, "_store_cycles"}, store_cyc - s0, exp_store);
    check({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  pmc_data_t d1, d1n, d3, d5, e2, e5, d7, e7;

  initial begin
    for (int l = 0; l < 16; l++) begin
      d1[l]  = 32'hA5A5_0000 + 32'(l);
      d1n[l] = ~d1[l];
      d3[l]  = 32'h0F0F_0000 | 32'(l * 16);
      d5[l]  = 32'h1234_5670 + 32'(l);
      e5[l]  = 32'h2345_6700 + 32'(l * 16);
      e2[l]  = 32'h0000_00FF;
      d7[l]  = 32'h0000_FFFF << l;
      e7[l]  = {d7[l][23:0], d7[l][31:24]};
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_din", din, '0);
    check("rst_outs", {sdo, clk_sh, store, busy, done}, '0);
    rst_n = 1'b1;

    run("loop32", d1, 6'd32, 8'd1, 1'b0, 1'b1, 16'h0000, d1, 65, 32, 65, 0);
    run("ones8", '0, 6'd8, 8'd3, 1'b0, 1'b0, 16'hFFFF, e2, 49, 8, 49, 0);
    check("clk_sh_period", last_gap, 6);
    run("zero_bits", d3, 6'd0, 8'd5, 1'b0, 1'b0, 16'h0000, d3, 1, 0, 1, 0);
    run("clamp40", d1n, 6'd40, 8'd1, 1'b0, 1'b1, 16'h0000, d1n, 65, 32, 65, 0);
    run("store4", d5, 6'd4, 8'd2, 1'b1, 1'b0, 16'h0000, e5, 19, 4, 19, 2);
    check("store_clk_sh_low", store_hi_clk, 0);

    // Abort during bit 6 of a 32-bit shift
    begin
      int unsigned p0;
      @(posedge clk); #1;
      dout = d1; bit_cnt = 6'd32; half_div = 8'd1; store_en = 1'b0; loop_en = 1'b1;
      start = 1'b1; p0 = pulses;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_outs", {busy, clk_sh, store, done}, '0);
      check("abort_pulses", pulses - p0, 5);
      repeat (80) @(negedge clk);
      check("abort_din_kept", din, e5);
    end

    // Second start while busy is ignored
    begin
      exp_t e;
      @(posedge clk); #1;
      dout = d7; bit_cnt = 6'd8; half_div = 8'd1; loop_en = 1'b1; start = 1'b1;
      e.din = e7; e.at = cyc + 17;
      exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      dout = d3; bit_cnt = 6'd0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle("restart");
      repeat (30) @(negedge clk);
      check("restart_sb_empty", exp_q.size(), 0);
    end

    // Asynchronous reset mid-shift
    @(posedge clk); #1;
    dout = d1; bit_cnt = 6'd32; half_div = 8'd2; loop_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_din", din, '0);
    check("arst_outs", {sdo, clk_sh, store, busy, done}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_idle", {busy, clk_sh}, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
